vga_dither_out: RTL and testbench

VGA_DITHER_OUT -- requirements
Module: vga_dither_out

---
 rtl/vga_dither_out.sv | 169 ++++++++++++++++
 tb/tb_vga_dither_out.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_dither_out.sv
// Ordered-dither output stage: reduces IN_BITS colour to OUT_BITS DAC pins with a
// 2-stage pipeline. Define VGA_DITHER_TEMPORAL_EN to alternate the pattern each frame.
module vga_dither_out #(
    parameter int unsigned IN_BITS  = 6,
    parameter int unsigned OUT_BITS = 3,
    parameter int unsigned MATRIX   = 4,
    parameter int unsigned SYNC_POL = 0
) (
    input  logic                clk_vga,
    input  logic                reset,
    input  logic                ce_pix,
    input  logic [IN_BITS-1:0]  r_in,
    input  logic [IN_BITS-1:0]  g_in,
    input  logic [IN_BITS-1:0]  b_in,
    input  logic                hsync_in,
    input  logic                vsync_in,
    input  logic                blank_in,
    output logic [OUT_BITS-1:0] r_out,
    output logic [OUT_BITS-1:0] g_out,
    output logic [OUT_BITS-1:0] b_out,
    output logic                hsync_out,
    output logic                vsync_out
);

    localparam int unsigned D   = IN_BITS - OUT_BITS;
    localparam int unsigned CW  = IN_BITS + 1;
    localparam int unsigned SHR = (D <= 4) ? (4 - D) : 0;
    localparam int unsigned SHL = (D > 4) ? (D - 4) : 0;
    localparam logic        ACT = (SYNC_POL != 0);
    localparam logic [CW-1:0] MAXV = CW'((1 << OUT_BITS) - 1);

    logic [1:0]         x;
    logic [1:0]         y;
    logic [1:0]         xe;
    logic               hs_lead;
    logic               vs_lead;
    logic [3:0]         t4;
    logic [3:0]         t2;
    logic [3:0]         t;
    logic [CW-1:0]      th;

    logic [IN_BITS-1:0] r_q;
    logic [IN_BITS-1:0] g_q;
    logic [IN_BITS-1:0] b_q;
    logic [CW-1:0]      th_q;
    logic               blank_q;
    logic               hs_q;
    logic               vs_q;

    // Rounds a channel up by the threshold, drops D bits, clamps to full scale.
    function automatic logic [OUT_BITS-1:0] dither(input logic [IN_BITS-1:0] c,
                                                   input logic [CW-1:0] thr);
        logic [CW-1:0] q;
        q = (CW'(c) + thr) >> D;
        return (q > MAXV) ? OUT_BITS'(MAXV) : OUT_BITS'(q);
    endfunction

`ifdef VGA_DITHER_TEMPORAL_EN
    logic f;

    // Frame parity flips the column pattern on alternate frames.
    always_ff @(posedge clk_vga) begin
        if (reset) begin
            f <= 1'b0;
        end else if (ce_pix && vs_lead) begin
            f <= ~f;
        end
    end

    always_comb begin
        xe = x ^ {f, f};
    end
`else
    always_comb begin
        xe = x;
    end
`endif

    // Sync edges are judged against the stage-1 copy of the previous pixel's sync.
    always_comb begin
        hs_lead = (hsync_in == ACT) && (hs_q != ACT);
        vs_lead = (vsync_in == ACT) && (vs_q != ACT);
    end

    // Threshold lookup and scaling to the number of dropped bits.
    always_comb begin
        t4 = 4'd0;
        case ({y, xe})
            4'd0:  t4 = 4'd0;
            4'd1:  t4 = 4'd8;
            4'd2:  t4 = 4'd2;
            4'd3:  t4 = 4'd10;
            4'd4:  t4 = 4'd12;
            4'd5:  t4 = 4'd4;
            4'd6:  t4 = 4'd14;
            4'd7:  t4 = 4'd6;
            4'd8:  t4 = 4'd3;
            4'd9:  t4 = 4'd11;
            4'd10: t4 = 4'd1;
            4'd11: t4 = 4'd9;
            4'd12: t4 = 4'd15;
            4'd13: t4 = 4'd7;
            4'd14: t4 = 4'd13;
            4'd15: t4 = 4'd5;
            default: t4 = 4'd0;
        endcase
        t2 = 4'd0;
        case ({y[0], xe[0]})
            2'd0:    t2 = 4'd0;
            2'd1:    t2 = 4'd8;
            2'd2:    t2 = 4'd12;
            2'd3:    t2 = 4'd4;
            default: t2 = 4'd0;
        endcase
        t  = (MATRIX == 2) ? t2 : t4;
        th = CW'((32'(t) >> SHR) << SHL);
    end

    // Pixel position within the dither matrix.
    always_ff @(posedge clk_vga) begin
        if (reset) begin
            x <= 2'd0;
            y <= 2'd0;
        end else if (ce_pix) begin
            if (hs_lead) begin
                x <= 2'd0;
            end else if (!blank_in) begin
                x <= 2'(x + 2'd1);
            end
            if (vs_lead) begin
                y <= 2'd0;
            end else if (hs_lead) begin
                y <= 2'(y + 2'd1);
            end
        end
    end

    // Stage 1 captures pixel and threshold; stage 2 produces the DAC values.
    always_ff @(posedge clk_vga) begin
        if (reset) begin
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
            th_q      <= '0;
            blank_q   <= 1'b0;
            hs_q      <= ~ACT;
            vs_q      <= ~ACT;
            r_out     <= '0;
            g_out     <= '0;
            b_out     <= '0;
            hsync_out <= ~ACT;
            vsync_out <= ~ACT;
        end else if (ce_pix) begin
            r_q       <= r_in;
            g_q       <= g_in;
            b_q       <= b_in;
            th_q      <= th;
            blank_q   <= blank_in;
            hs_q      <= hsync_in;
            vs_q      <= vsync_in;
            r_out     <= blank_q ? '0 : dither(r_q, th_q);
            g_out     <= blank_q ? '0 : dither(g_q, th_q);
            b_out     <= blank_q ? '0 : dither(b_q, th_q);
            hsync_out <= hs_q;
            vsync_out <= vs_q;
        end
    end

endmodule

// File: tb/tb_vga_dither_out.sv
// Bench for vga_dither_out: a default 6->3 bit instance and a 6->6 bit passthrough
// instance share stimulus and are compared against a table-driven position model.
module tb_vga_dither_out;

    localparam int D = 3;

    logic       clk_vga = 1'b0;
    logic       reset;
    logic       ce_pix;
    logic [5:0] r_in, g_in, b_in;
    logic       hsync_in, vsync_in, blank_in;
    logic [2:0] r_out, g_out, b_out;
    logic       hsync_out, vsync_out;
    logic [5:0] rw_out, gw_out, bw_out;
    logic       hsw_out, vsw_out;

    vga_dither_out u_dut (
        .clk_vga(clk_vga), .reset(reset), .ce_pix(ce_pix),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_in(blank_in),
        .r_out(r_out), .g_out(g_out), .b_out(b_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out)
    );

    vga_dither_out #(.OUT_BITS(6)) u_wide (
        .clk_vga(clk_vga), .reset(reset), .ce_pix(ce_pix),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_in(blank_in),
        .r_out(rw_out), .g_out(gw_out), .b_out(bw_out),
        .hsync_out(hsw_out), .vsync_out(vsw_out)
    );

    always #5 clk_vga = ~clk_vga;

    typedef struct {
        logic [2:0] r, g, b;
        logic [5:0] rw, gw, bw;
        logic       hs, vs;
    } exp_t;

    typedef struct {
        logic [5:0] r, g, b;
        logic       hs, vs, bl;
    } px_t;

    int   tests = 0;
    int   fails = 0;
    int   mx, my, mf;
    logic prev_hs, prev_vs;
    exp_t q[$];
    exp_t cur;
    px_t  stim[$];
    exp_t got[$];
    exp_t want[$];
    int   bayer[4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};

    function automatic exp_t rst_exp();
        exp_t e;
        e.r = 0; e.g = 0; e.b = 0; e.rw = 0; e.gw = 0; e.bw = 0; e.hs = 1'b1; e.vs = 1'b1;
        return e;
    endfunction

    function automatic logic [2:0] dith(input int c, input int t);
        int th, v;
        th = (D <= 4) ? (t >> (4 - D)) : (t << (D - 4));
        v  = (c + th) >> D;
        return (v > 7) ? 3'd7 : 3'(v);
    endfunction

    function automatic exp_t snap();
        exp_t e;
        e.r = r_out; e.g = g_out; e.b = b_out;
        e.rw = rw_out; e.gw = gw_out; e.bw = bw_out;
        e.hs = hsync_out; e.vs = vsync_out;
        return e;
    endfunction

    function automatic px_t mk(input int r, input int g, input int b,
                               input logic hs, input logic vs, input logic bl);
        px_t p;
        p.r = 6'(r); p.g = 6'(g); p.b = 6'(b); p.hs = hs; p.vs = vs; p.bl = bl;
        return p;
    endfunction

    task automatic model_reset();
        mx = 0; my = 0; mf = 0; prev_hs = 1'b1; prev_vs = 1'b1;
        q.delete();
        q.push_back(rst_exp());
        cur = rst_exp();
    endtask

    task automatic apply_reset(input logic ce);
        reset = 1'b1; ce_pix = ce;
        @(posedge clk_vga); #1;
        reset = 1'b0; ce_pix = 1'b0;
        model_reset();
    endtask

    // Drive one enabled pixel; the model predicts it and pops what should appear now.
    task automatic pixel(input px_t p);
        exp_t e;
        int   xe;
        logic hl, vl;
        r_in = p.r; g_in = p.g; b_in = p.b;
        hsync_in = p.hs; vsync_in = p.vs; blank_in = p.bl; ce_pix = 1'b1;
        xe = mx;
`ifdef VGA_DITHER_TEMPORAL_EN
        if (mf != 0) xe = mx ^ 3;
`endif
        e.r  = p.bl ? 3'd0 : dith(p.r, bayer[my][xe]);
        e.g  = p.bl ? 3'd0 : dith(p.g, bayer[my][xe]);
        e.b  = p.bl ? 3'd0 : dith(p.b, bayer[my][xe]);
        e.rw = p.bl ? 6'd0 : p.r;
        e.gw = p.bl ? 6'd0 : p.g;
        e.bw = p.bl ? 6'd0 : p.b;
        e.hs = p.hs; e.vs = p.vs;
        q.push_back(e);
        hl = (p.hs == 1'b0) && (prev_hs == 1'b1);
        vl = (p.vs == 1'b0) && (prev_vs == 1'b1);
        if (hl) mx = 0; else if (!p.bl) mx = (mx + 1) % 4;
        if (vl) my = 0; else if (hl) my = (my + 1) % 4;
        if (vl) mf = mf ^ 1;
        prev_hs = p.hs; prev_vs = p.vs;
        @(posedge clk_vga); #1;
        ce_pix = 1'b0;
        cur = q.pop_front();
    endtask

    task automatic hold_tick();
        ce_pix = 1'b0;
        @(posedge clk_vga); #1;
    endtask

    task automatic run_seq();
        got.delete(); want.delete();
        foreach (stim[i]) begin
            pixel(stim[i]);
            got.push_back(snap());
            want.push_back(cur);
        end
        stim.delete();
    endtask

    // Four 4-pixel lines covering every matrix position, starting on a vsync edge.
    task automatic build_block(input int val);
        stim.push_back(mk(0, 0, 0, 1, 1, 1));
        stim.push_back(mk(0, 0, 0, 1, 1, 1));
        for (int l = 0; l < 4; l++) begin
            stim.push_back(mk(0, 0, 0, 0, (l == 0) ? 1'b0 : 1'b1, 1));
            stim.push_back(mk(0, 0, 0, 1, 1, 1));
            for (int c = 0; c < 4; c++) stim.push_back(mk(val, val, val, 1, 1, 0));
        end
        stim.push_back(mk(0, 0, 0, 1, 1, 1));
        stim.push_back(mk(0, 0, 0, 1, 1, 1));
    endtask

    task automatic test_reset();
        r_in = 6'd63; g_in = 6'd63; b_in = 6'd63;
        hsync_in = 1'b0; vsync_in = 1'b0; blank_in = 1'b0;
        apply_reset(1'b0);
        tests++; if (r_out !== 3'd0) begin fails++; $display("FAIL reset r_out: got %0d want 0", r_out); end
        tests++; if (g_out !== 3'd0) begin fails++; $display("FAIL reset g_out: got %0d want 0", g_out); end
        tests++; if (b_out !== 3'd0) begin fails++; $display("FAIL reset b_out: got %0d want 0", b_out); end
        tests++; if (hsync_out !== 1'b1) begin fails++; $display("FAIL reset hsync_out: got %b want 1", hsync_out); end
        tests++; if (vsync_out !== 1'b1) begin fails++; $display("FAIL reset vsync_out: got %b want 1", vsync_out); end
        tests++; if (rw_out !== 6'd0) begin fails++; $display("FAIL reset wide r_out: got %0d want 0", rw_out); end
    endtask

    task automatic test_saturation();
        int n;
        for (int k = 0; k < 2; k++) begin
            build_block(k == 0 ? 0 : 63);
            run_seq();
            n = 0;
            foreach (got[i]) begin
                if (i >= 1 && got[i].r == 3'd7) n++;
                tests++;
                if (got[i].r !== want[i].r) begin
                    fails++; $display("FAIL sat r_out[%0d]: got %0d want %0d", i, got[i].r, want[i].r);
                end
            end
            tests++;
            if (n !== ((k == 0) ? 0 : 16)) begin
                fails++; $display("FAIL sat full-scale count: got %0d want %0d", n, (k == 0) ? 0 : 16);
            end
        end
    endtask

    task automatic test_bayer_map();
        int ones;
        build_block(4);
        run_seq();
        ones = 0;
        foreach (got[i]) begin
            if (i >= 1 && got[i].r == 3'd1) ones++;
            tests++;
            if (got[i].r !== want[i].r || got[i].g !== want[i].g) begin
                fails++; $display("FAIL bayer rg_out[%0d]: got %0d/%0d want %0d/%0d",
                                  i, got[i].r, got[i].g, want[i].r, want[i].g);
            end
        end
        tests++; if (ones !== 8) begin fails++; $display("FAIL bayer ones count: got %0d want 8", ones); end
    endtask

    task automatic test_latency_hold();
        pixel(mk(0, 0, 0, 1, 1, 1));
        pixel(mk(0, 0, 0, 1, 1, 1));
        pixel(mk(63, 0, 0, 0, 1, 0));
        tests++; if (hsync_out !== 1'b1) begin fails++; $display("FAIL lat hsync early: got %b want 1", hsync_out); end
        pixel(mk(0, 0, 0, 1, 1, 1));
        tests++; if (r_out !== 3'd7) begin fails++; $display("FAIL lat r_out: got %0d want 7", r_out); end
        tests++; if (hsync_out !== 1'b0) begin fails++; $display("FAIL lat hsync_out: got %b want 0", hsync_out); end
        for (int k = 0; k < 5; k++) begin
            r_in = 6'(k * 11); hsync_in = 1'(k); blank_in = 1'(k + 1);
            hold_tick();
            tests++;
            if (r_out !== 3'd7 || hsync_out !== 1'b0) begin
                fails++; $display("FAIL hold frozen[%0d]: got %0d/%b want 7/0", k, r_out, hsync_out);
            end
        end
        pixel(mk(0, 0, 0, 1, 1, 1));
        tests++;
        if (r_out !== 3'd0 || hsync_out !== 1'b1) begin
            fails++; $display("FAIL lat resume: got %0d/%b want 0/1", r_out, hsync_out);
        end
    endtask

    task automatic test_blank();
        pixel(mk(63, 63, 63, 1, 1, 1));
        pixel(mk(0, 0, 0, 1, 1, 1));
        tests++;
        if (r_out !== 3'd0 || g_out !== 3'd0 || b_out !== 3'd0 || rw_out !== 6'd0) begin
            fails++; $display("FAIL blank rgb: got %0d %0d %0d wide %0d want 0", r_out, g_out, b_out, rw_out);
        end
    endtask

    task automatic test_reset_midline();
        pixel(mk(63, 63, 63, 1, 1, 0));
        pixel(mk(63, 63, 63, 1, 1, 0));
        pixel(mk(63, 63, 63, 0, 0, 0));
        r_in = 6'd63; g_in = 6'd63; b_in = 6'd63; hsync_in = 1'b0; vsync_in = 1'b0; blank_in = 1'b0;
        apply_reset(1'b1);
        tests++;
        if (r_out !== 3'd0 || hsync_out !== 1'b1 || vsync_out !== 1'b1) begin
            fails++; $display("FAIL midreset outputs: got %0d/%b/%b want 0/1/1", r_out, hsync_out, vsync_out);
        end
        pixel(mk(4, 4, 4, 1, 1, 0));
        tests++; if (r_out !== 3'd0) begin fails++; $display("FAIL midreset stage: got %0d want 0", r_out); end
        pixel(mk(4, 4, 4, 1, 1, 0));
        tests++; if (r_out !== 3'd0) begin fails++; $display("FAIL midreset x0: got %0d want 0", r_out); end
        pixel(mk(0, 0, 0, 1, 1, 1));
        tests++; if (r_out !== 3'd1) begin fails++; $display("FAIL midreset x1: got %0d want 1", r_out); end
    endtask

    task automatic test_frames();
        logic [2:0] want1;
`ifdef VGA_DITHER_TEMPORAL_EN
        want1 = 3'd1;
`else
        want1 = 3'd0;
`endif
        apply_reset(1'b0);
        pixel(mk(4, 4, 4, 1, 1, 0));
        pixel(mk(0, 0, 0, 0, 0, 1));
        tests++; if (r_out !== 3'd0) begin fails++; $display("FAIL frame0 r_out: got %0d want 0", r_out); end
        pixel(mk(4, 4, 4, 1, 1, 0));
        pixel(mk(0, 0, 0, 1, 1, 1));
        tests++; if (r_out !== want1) begin fails++; $display("FAIL frame1 r_out: got %0d want %0d", r_out, want1); end
    endtask

    task automatic test_random();
        for (int l = 0; l < 10; l++) begin
            int w;
            w = $urandom_range(1, 3);
            for (int s = 0; s < w; s++)
                stim.push_back(mk(0, 0, 0, 0, (l % 4 == 0) ? 1'b0 : 1'b1, 1));
            stim.push_back(mk($urandom_range(0, 63), 0, 0, 1, 1, 1));
            for (int c = 0; c < int'($urandom_range(3, 12)); c++)
                stim.push_back(mk($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63),
                                  1, 1, ($urandom_range(0, 7) == 0)));
        end
        run_seq();
        foreach (got[i]) begin
            tests++;
            if (got[i].r !== want[i].r || got[i].g !== want[i].g || got[i].b !== want[i].b) begin
                fails++; $display("FAIL rand rgb[%0d]: got %0d %0d %0d want %0d %0d %0d",
                                  i, got[i].r, got[i].g, got[i].b, want[i].r, want[i].g, want[i].b);
            end
            tests++;
            if (got[i].rw !== want[i].rw || got[i].gw !== want[i].gw || got[i].bw !== want[i].bw) begin
                fails++; $display("FAIL rand wide[%0d]: got %0d %0d %0d want %0d %0d %0d",
                                  i, got[i].rw, got[i].gw, got[i].bw, want[i].rw, want[i].gw, want[i].bw);
            end
            tests++;
            if (got[i].hs !== want[i].hs || got[i].vs !== want[i].vs) begin
                fails++; $display("FAIL rand sync[%0d]: got %b%b want %b%b",
                                  i, got[i].hs, got[i].vs, want[i].hs, want[i].vs);
            end
        end
        tests++;
        if (hsw_out !== hsync_out || vsw_out !== vsync_out) begin
            fails++; $display("FAIL rand wide sync: got %b%b want %b%b", hsw_out, vsw_out, hsync_out, vsync_out);
        end
    endtask

    initial begin
        reset = 1'b0; ce_pix = 1'b0;
        r_in = '0; g_in = '0; b_in = '0;
        hsync_in = 1'b1; vsync_in = 1'b1; blank_in = 1'b1;
        #2;
        test_reset();
        test_saturation();
        test_bayer_map();
        test_latency_hold();
        test_blank();
        test_reset_midline();
        test_frames();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", tests, fails);
        $finish;
    end

endmodule
